// File: rtl/miriscv_div_ctrl.sv
// MDU divider front-end: request decode, divider handshake and a one-entry
// result cache that lets DIV/REM pairs on the same operands skip the divider.

package miriscv_div_ctrl_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MDU_OP_WIDTH = 3;

    typedef enum logic [MDU_OP_WIDTH-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    // Cache tag: operand pair plus signedness of the division that produced it
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            s;
    } div_tag_t;

    typedef struct packed {
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
    } div_data_t;

endpackage

module miriscv_div_ctrl
    import miriscv_div_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,

    input  logic                    div_req_i,
    input  logic [XLEN-1:0]         port_a_i,
    input  logic [XLEN-1:0]         port_b_i,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic                    kill_i,
    input  logic                    keep_i,

    output logic [XLEN-1:0]         result_o,
    output logic                    result_valid_o,
    output logic                    stall_req_o,

    output logic                    div_start_o,
    output logic                    div_zero_o,
    output logic                    div_kill_o,
    output logic                    div_keep_o,
    input  logic [XLEN-1:0]         div_result_i,
    input  logic [XLEN-1:0]         rem_result_i,
    input  logic                    div_stall_req_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e    state_q;
    state_e    state_d;

    logic      c_v_q;
    div_tag_t  c_tag_q;
    div_data_t c_data_q;

    logic      is_div_op;
    logic      valid_req;
    logic      is_rem;
    logic      is_signed;
    div_tag_t  cur_tag;
    logic      hit;
    logic      cache_we;

    // Request decode and cache lookup
    always_comb begin
        is_div_op = (mdu_op_i == MDU_DIV)  || (mdu_op_i == MDU_DIVU) ||
                    (mdu_op_i == MDU_REM)  || (mdu_op_i == MDU_REMU);
        valid_req = div_req_i && is_div_op;
        is_rem    = (mdu_op_i == MDU_REM)  || (mdu_op_i == MDU_REMU);
        is_signed = (mdu_op_i == MDU_DIV)  || (mdu_op_i == MDU_REM);
        cur_tag   = '{a: port_a_i, b: port_b_i, s: is_signed};
        hit       = CACHE_EN && c_v_q && (c_tag_q == cur_tag);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; kill always wins and suppresses the result
    always_comb begin
        state_d        = state_q;
        div_start_o    = 1'b0;
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        result_o       = '0;
        cache_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_req && !kill_i) begin
                    if (hit) begin
                        result_valid_o = 1'b1;
                        result_o       = is_rem ? c_data_q.r : c_data_q.q;
                    end else begin
                        div_start_o = 1'b1;
                        stall_req_o = 1'b1;
                        state_d     = BUSY;
                    end
                end
            end

            BUSY: begin
                div_start_o = 1'b1;
                if (kill_i) begin
                    state_d = IDLE;
                end else if (div_stall_req_i) begin
                    stall_req_o = 1'b1;
                end else begin
                    cache_we       = 1'b1;
                    result_valid_o = 1'b1;
                    result_o       = is_rem ? rem_result_i : div_result_i;
                    state_d        = keep_i ? HOLD : IDLE;
                end
            end

            HOLD: begin
                // Start stays high so the divider parks in its finish state
                div_start_o = 1'b1;
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    result_valid_o = 1'b1;
                    result_o       = is_rem ? c_data_q.r : c_data_q.q;
                    if (!keep_i) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (!arstn_i) begin
            div_start_o    = 1'b0;
            stall_req_o    = 1'b0;
            result_valid_o = 1'b0;
            result_o       = '0;
            cache_we       = 1'b0;
        end
    end

    // Single-entry result cache, filled on every unkilled divider completion
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            c_v_q    <= 1'b0;
            c_tag_q  <= '0;
            c_data_q <= '0;
        end else if (cache_we) begin
            c_v_q    <= 1'b1;
            c_tag_q  <= cur_tag;
            c_data_q <= '{q: div_result_i, r: rem_result_i};
        end
    end

    assign div_zero_o = arstn_i && (port_b_i == '0);
    assign div_kill_o = arstn_i && kill_i;
    assign div_keep_o = arstn_i && keep_i;

endmodule

// File: tb/tb_miriscv_div_ctrl.sv
// Bench for miriscv_div_ctrl: behavioural divider with programmable latency
// and an operand-level cache model; directed cases then a randomized run.

module tb_miriscv_div_ctrl;
    import miriscv_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        arstn;
    logic        div_req;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [2:0]  mdu_op;
    logic        kill;
    logic        keep;
    logic [31:0] result;
    logic        result_valid;
    logic        stall_req;
    logic        div_start;
    logic        div_zero;
    logic        div_kill;
    logic        div_keep;
    logic [31:0] div_result;
    logic [31:0] rem_result;
    logic        div_stall_req;

    int n_cmp  = 0;
    int n_fail = 0;

    int lat = 1;
    int cnt;

    logic        mv;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        ms;

    always #5 clk = ~clk;

    miriscv_div_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .div_req_i       (div_req),
        .port_a_i        (port_a),
        .port_b_i        (port_b),
        .mdu_op_i        (mdu_op),
        .kill_i          (kill),
        .keep_i          (keep),
        .result_o        (result),
        .result_valid_o  (result_valid),
        .stall_req_o     (stall_req),
        .div_start_o     (div_start),
        .div_zero_o      (div_zero),
        .div_kill_o      (div_kill),
        .div_keep_o      (div_keep),
        .div_result_i    (div_result),
        .rem_result_i    (rem_result),
        .div_stall_req_i (div_stall_req)
    );

    function automatic logic is_sgn(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_remop(input logic [2:0] op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    // RISC-V division semantics: {quotient, remainder}
    function automatic logic [63:0] ref_qr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_sgn(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (is_sgn(op)) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qr;
        qr = ref_qr(op, a, b);
        return is_remop(op) ? qr[31:0] : qr[63:32];
    endfunction

    // Divider model: stalls for 'lat' cycles after start, then holds done while start stays high
    always @(posedge clk or negedge arstn) begin
        if (!arstn) cnt <= 0;
        else if (!div_start || div_kill) cnt <= 0;
        else if (cnt < lat) cnt <= cnt + 1;
    end

    assign div_stall_req = div_start && (cnt < lat);
    assign div_result    = ref_qr(mdu_op, port_a, port_b)[63:32];
    assign rem_result    = ref_qr(mdu_op, port_a, port_b)[31:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_start"}, 32'(div_start), 32'd0);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
    endtask

    task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int keep_n, input int dlat);
        logic [31:0] exp;
        logic        hit;
        logic        done;
        int          c;
        lat = dlat;
        @(posedge clk); #1;
        div_req = 1'b1; mdu_op = op; port_a = a; port_b = b;
        keep = (keep_n > 0); kill = 1'b0;
        exp = ref_res(op, a, b);
        hit = mv && ma == a && mb == b && ms == is_sgn(op);
        @(negedge clk);
        chk("div_zero", 32'(div_zero), 32'(b == 32'd0));
        chk("div_keep", 32'(div_keep), 32'(keep));
        if (hit) begin
            chk("hit_valid", 32'(result_valid), 32'd1);
            chk("hit_result", result, exp);
            chk("hit_stall", 32'(stall_req), 32'd0);
            chk("hit_start", 32'(div_start), 32'd0);
        end else begin
            chk("miss_stall", 32'(stall_req), 32'd1);
            chk("miss_start", 32'(div_start), 32'd1);
            chk("miss_valid", 32'(result_valid), 32'd0);
            done = 1'b0;
            c = 0;
            while (!done && c < 100) begin
                @(negedge clk);
                c++;
                if (!stall_req) done = 1'b1;
            end
            chk("done_bound", 32'(done), 32'd1);
            chk("latency", 32'(c), 32'(dlat));
            chk("done_valid", 32'(result_valid), 32'd1);
            chk("done_result", result, exp);
            mv = 1'b1; ma = a; mb = b; ms = is_sgn(op);
            for (int k = 0; k < keep_n; k++) begin
                @(negedge clk);
                chk("hold_valid", 32'(result_valid), 32'd1);
                chk("hold_result", result, exp);
                chk("hold_start", 32'(div_start), 32'd1);
                chk("hold_stall", 32'(stall_req), 32'd0);
            end
            if (keep_n > 0) begin
                @(posedge clk); #1;
                keep = 1'b0;
                @(negedge clk);
                chk("hold_exit_valid", 32'(result_valid), 32'd1);
                chk("hold_exit_result", result, exp);
            end
        end
        @(posedge clk); #1;
        div_req = 1'b0; keep = 1'b0;
        @(negedge clk);
        chk_idle("after");
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        mv = 1'b0; ma = '0; mb = '0; ms = 1'b0;

        // Outputs forced low during reset even with live inputs
        arstn = 1'b0; div_req = 1'b1; mdu_op = MDU_DIV; port_a = 32'd9; port_b = 32'd0;
        kill = 1'b1; keep = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_zero", 32'(div_zero), 32'd0);
        chk("reset_kill", 32'(div_kill), 32'd0);
        chk("reset_keep", 32'(div_keep), 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1; div_req = 1'b0; kill = 1'b0; keep = 1'b0;

        // Non-divide op is ignored
        @(posedge clk); #1;
        div_req = 1'b1; mdu_op = MDU_MUL; port_a = 32'd6; port_b = 32'd3;
        @(negedge clk);
        chk_idle("mul_ignored");
        @(posedge clk); #1;
        div_req = 1'b0;

        run_req(MDU_DIV,  32'd100, 32'd7, 0, 36);
        run_req(MDU_REM,  32'd100, 32'd7, 0, 5);
        run_req(MDU_DIVU, 32'd100, 32'd7, 0, 10);
        run_req(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 0, 12);
        run_req(MDU_REM,  32'hFFFF_FFF9, 32'd2, 0, 12);
        run_req(MDU_DIVU, 32'd5, 32'd0, 0, 8);
        run_req(MDU_REMU, 32'd5, 32'd0, 0, 8);

        // Kill ten cycles into a miss; cached entry survives
        lat = 30;
        @(posedge clk); #1;
        div_req = 1'b1; mdu_op = MDU_DIV; port_a = 32'd12345; port_b = 32'd17;
        @(negedge clk);
        chk("kill_miss_start", 32'(div_start), 32'd1);
        repeat (10) @(negedge clk);
        chk("kill_busy_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        kill = 1'b1;
        @(negedge clk);
        chk("kill_div_kill", 32'(div_kill), 32'd1);
        chk("kill_valid", 32'(result_valid), 32'd0);
        chk("kill_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0; div_req = 1'b0;
        @(negedge clk);
        chk_idle("post_kill");
        run_req(MDU_REMU, 32'd5, 32'd0, 0, 8);

        run_req(MDU_DIV, 32'd1000, 32'd3, 3, 8);
        run_req(MDU_REM, 32'd1000, 32'd3, 2, 8);
        run_req(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4);
        run_req(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4);

        // Asynchronous reset in the middle of a miss clears the cache
        lat = 20;
        @(posedge clk); #1;
        div_req = 1'b1; mdu_op = MDU_DIV; port_a = 32'd777; port_b = 32'd5; keep = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        arstn = 1'b0; kill = 1'b1;
        #1;
        chk_idle("midreset");
        chk("midreset_kill", 32'(div_kill), 32'd0);
        chk("midreset_keep", 32'(div_keep), 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1; kill = 1'b0; keep = 1'b0; div_req = 1'b0;
        mv = 1'b0;
        run_req(MDU_DIV, 32'd777, 32'd5, 0, 6);
        run_req(MDU_REM, 32'd777, 32'd5, 1, 6);

        // Randomized mix, biased toward operand reuse so hits occur
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            op  = 3'(4 + $urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = $urandom; b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end else if (sel >= 5) begin
                a = $urandom;
                b = (sel >= 8) ? $urandom : 32'($urandom_range(1, 1000));
                if (b == 32'd0) b = 32'd3;
            end
            run_req(op, a, b, int'($urandom_range(0, 2)), int'($urandom_range(1, 36)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
